ps2_temp_entry: RTL and testbench
=================================

Name: ps2_temp_entry

Overview:
- Keyboard-side front end for the temperature controller. Receives PS/2 keyboard frames, decodes make codes for the digits 0-9, Enter and Backspace, and assembles a decimal setpoint of 0-31.
- On Enter it drives the 5-bit temperatura bus and pulses lect. These are the inputs the comparator/FSM/7-seg top consumes.
- Sits between the board PS/2 pins and that top level, in the same clock domain.

Parameters:
- FILTER_LEN, 8: consecutive identical samples of synchronised ps2_clk required before a level change is accepted.
- TIMEOUT_CYC, 50000: clock cycles without a ps2_clk falling edge mid-frame before the partial frame is dropped.
- TEMP_MAX, 31: largest committable value.

Ports:
- clock  in  1  system clock, single domain.
- reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous).
- ps2_data  in  1  raw PS/2 data pin (asynchronous).
- temperatura  out  5  last committed setpoint, binary 0-31.
- lect  out  1  one-cycle pulse when temperatura is updated.
- entry_err  out  1  one-cycle pulse on a rejected entry.
- digit_count  out  2  digits currently buffered (0-2).
- frame_err  out  1  one-cycle pulse on a bad PS/2 frame.

Behaviour:
- Reset (reset=0, asynchronous): temperatura=0, lect=0, entry_err=0, frame_err=0, digit_count=0, accumulator=0, break/extended flags cleared, receiver in IDLE.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - ps2_clk then passes through the FILTER_LEN glitch filter.
  - A falling edge of the filtered clock samples the synchronised ps2_data.
- Receiver FSM, states IDLE, SHIFT, CHECK:
  - IDLE: a falling edge with data=0 (start bit) -> SHIFT, bit counter=0. A falling edge with data=1 stays in IDLE, no error.
  - SHIFT: collect 8 data bits LSB first, then the parity bit, then the stop bit (10 edges total) -> CHECK.
  - CHECK (one cycle): the frame is valid if parity over data+parity is odd and stop=1. Valid -> byte strobe to the decoder. Invalid -> frame_err pulse, byte discarded. Always -> IDLE.
  - Timeout: in SHIFT, TIMEOUT_CYC cycles with no falling edge -> IDLE, frame_err pulse, partial data discarded.
- Decoder, acting on each byte strobe:
  - 0xE0 sets the ext flag; 0xF0 sets the brk flag; neither is otherwise acted on.
  - Any other byte with brk=1 is a release code: ignored, then brk and ext are cleared.
  - Otherwise the byte is a make code, ext is ignored (keypad Enter E0 5A equals 5A), and both flags are cleared.
- Make codes:
  - Digits: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
  - Digit with digit_count<2: acc = acc*10 + d (acc is 7 bits, max 99), digit_count+1.
  - Digit with digit_count=2: entry_err pulse, acc and count unchanged.
  - Backspace 0x66: acc=0, digit_count=0, no pulse.
  - Enter 0x5A with digit_count=0: ignored.
  - Enter 0x5A with acc<=TEMP_MAX: temperatura=acc[4:0], lect pulse, acc and count cleared.
  - Enter 0x5A with acc>TEMP_MAX: entry_err pulse, temperatura unchanged, acc and count cleared.
  - All other codes: ignored.
- Timing:
  - temperatura and lect update in the same cycle, one cycle after the CHECK cycle.
  - Pulses are exactly one clock wide.
  - temperatura holds its value between commits.
- Reset asserted mid-frame: the receiver and the partial entry are dropped immediately. After release the block waits in IDLE. A frame whose remaining bits arrive after reset release is not decoded as data unless those bits are themselves a well-formed frame.

Test Plan:
- Reset, then send frames 16, 2E, 5A (keys 1, 5, Enter) -> digit_count goes 1 then 2; single lect pulse; temperatura=15.
- Send 1E, 39 (with a corrupted parity bit), 5A -> frame_err pulse on the second frame; temperatura=2, lect pulse.
- Send 26, 45, 5A (value 30), then 26, 1E, 5A (value 32) -> first sets temperatura=30; second gives entry_err, no lect, temperatura stays 30.
- Send 16, F0, 16, 16, 66, 25, E0, 5A -> release code ignored; Backspace clears; keypad Enter commits temperatura=4.
- Send 16, 16, 16 -> third digit gives entry_err with digit_count=2; then 5A gives temperatura=11.
- Stop ps2_clk after 4 bits for more than TIMEOUT_CYC -> frame_err and IDLE; a 1-cycle ps2_clk glitch shorter than FILTER_LEN is ignored; reset low mid-frame -> all outputs 0.

Source files
------------

// File: rtl/ps2_temp_entry.sv
`default_nettype none
// ==========================================================================
// ps2_temp_entry : PS/2 keyboard receiver and decimal setpoint entry (0-31)
// Revision 1.0
// ==========================================================================
module ps2_temp_entry #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int TEMP_MAX    = 31
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [4:0] temperatura,
  output logic       lect,
  output logic       entry_err,
  output logic [1:0] digit_count,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, CHECK = 2'd2} rx_state_t;

  // Synchronisers and glitch filter; the bus idles high, so reset to 1.
  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          flt_q, flt_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          fall_w;

  always_comb begin
    flt_d     = flt_q;
    flt_cnt_d = flt_cnt_q;
    if (clk_s2_q == flt_q) begin
      flt_cnt_d = '0;
    end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
      flt_d     = clk_s2_q;
      flt_cnt_d = '0;
    end else begin
      flt_cnt_d = flt_cnt_q + 1'b1;
    end
  end

  assign fall_w = flt_q & ~flt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      flt_q     <= 1'b1;
      flt_cnt_q <= '0;
    end else begin
      clk_s1_q  <= ps2_clk;
      clk_s2_q  <= clk_s1_q;
      dat_s1_q  <= ps2_data;
      dat_s2_q  <= dat_s1_q;
      flt_q     <= flt_d;
      flt_cnt_q <= flt_cnt_d;
    end
  end

  // Receiver: shift_q ends up as {stop, parity, data[7:0]}.
  rx_state_t     state_q;
  logic [3:0]    bit_cnt_q;
  logic [9:0]    shift_q;
  logic [TW-1:0] tmo_q;
  logic          frame_err_q;
  logic          frame_ok_w;
  logic          byte_stb_w;

  assign frame_ok_w = (^shift_q[8:0]) & shift_q[9];
  assign byte_stb_w = (state_q == CHECK) && frame_ok_w;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fall_w && !dat_s2_q) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
            tmo_q     <= '0;
          end
        end
        SHIFT: begin
          if (fall_w) begin
            shift_q   <= {dat_s2_q, shift_q[9:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            tmo_q     <= '0;
            if (bit_cnt_q == 4'd9) state_q <= CHECK;
          end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        CHECK: begin
          if (!frame_ok_w) frame_err_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Key decoder and setpoint accumulator.
  logic [6:0] acc_q, acc_d;
  logic [1:0] cnt_q, cnt_d;
  logic       brk_q, brk_d, ext_q, ext_d;
  logic [4:0] temp_q, temp_d;
  logic       lect_q, lect_d, eerr_q, eerr_d;
  logic       is_digit_w;
  logic [3:0] digit_w;

  always_comb begin
    is_digit_w = 1'b1;
    digit_w    = 4'd0;
    case (shift_q[7:0])
      8'h45: digit_w = 4'd0;
      8'h16: digit_w = 4'd1;
      8'h1E: digit_w = 4'd2;
      8'h26: digit_w = 4'd3;
      8'h25: digit_w = 4'd4;
      8'h2E: digit_w = 4'd5;
      8'h36: digit_w = 4'd6;
      8'h3D: digit_w = 4'd7;
      8'h3E: digit_w = 4'd8;
      8'h46: digit_w = 4'd9;
      default: is_digit_w = 1'b0;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    brk_d  = brk_q;
    ext_d  = ext_q;
    temp_d = temp_q;
    lect_d = 1'b0;
    eerr_d = 1'b0;
    if (byte_stb_w) begin
      if (shift_q[7:0] == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q[7:0] == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (!brk_q) begin
          if (is_digit_w) begin
            if (cnt_q == 2'd2) begin
              eerr_d = 1'b1;
            end else begin
              acc_d = 7'(acc_q * 7'd10 + {3'b000, digit_w});
              cnt_d = cnt_q + 1'b1;
            end
          end else if (shift_q[7:0] == 8'h66) begin
            acc_d = '0;
            cnt_d = '0;
          end else if (shift_q[7:0] == 8'h5A && cnt_q != 2'd0) begin
            if (acc_q <= 7'(TEMP_MAX)) begin
              temp_d = acc_q[4:0];
              lect_d = 1'b1;
            end else begin
              eerr_d = 1'b1;
            end
            acc_d = '0;
            cnt_d = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      brk_q  <= 1'b0;
      ext_q  <= 1'b0;
      temp_q <= '0;
      lect_q <= 1'b0;
      eerr_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      brk_q  <= brk_d;
      ext_q  <= ext_d;
      temp_q <= temp_d;
      lect_q <= lect_d;
      eerr_q <= eerr_d;
    end
  end

  assign temperatura = temp_q;
  assign lect        = lect_q;
  assign entry_err   = eerr_q;
  assign digit_count = cnt_q;
  assign frame_err   = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_temp_entry.sv
`default_nettype none
// Directed testbench for ps2_temp_entry: PS/2 frames in, setpoint and pulses out.
module tb_ps2_temp_entry;

  localparam int HALF = 20;
  localparam int TMO  = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2_clk, ps2_data;
  logic [4:0] temperatura;
  logic       lect, entry_err, frame_err;
  logic [1:0] digit_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int lect_cnt = 0, eerr_cnt = 0, ferr_cnt = 0, width_err = 0, temp_err = 0;
  logic       lect_prev = 1'b0, eerr_prev = 1'b0, ferr_prev = 1'b0;
  logic [4:0] temp_prev = 5'd0;

  ps2_temp_entry #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO), .TEMP_MAX(31)) dut (
    .clock      (clk),
    .reset      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .temperatura(temperatura),
    .lect       (lect),
    .entry_err  (entry_err),
    .digit_count(digit_count),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse counters, pulse-width and "temperatura only moves with lect" monitor.
  always @(negedge clk) begin
    if (lect === 1'b1) lect_cnt++;
    if (entry_err === 1'b1) eerr_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
    if ((lect && lect_prev) || (entry_err && eerr_prev) || (frame_err && ferr_prev)) width_err++;
    if (rst_n && temperatura !== temp_prev && lect !== 1'b1) temp_err++;
    lect_prev = lect;
    eerr_prev = entry_err;
    ferr_prev = frame_err;
    temp_prev = temperatura;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic clear_counts();
    @(negedge clk);
    lect_cnt = 0;
    eerr_cnt = 0;
    ferr_cnt = 0;
  endtask

  task automatic send_bits(input logic [10:0] frm, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      ps2_data = frm[i];
      idle(HALF);
      ps2_clk = 1'b0;
      idle(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par = 1'b0);
    logic [10:0] frm;
    frm = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    send_bits(frm, 11);
    @(posedge clk);
    ps2_data = 1'b1;
    idle(40);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rst_n    = 1'b0;
    idle(5);
    @(negedge clk);
    total_cnt++;
    if ({temperatura, lect, entry_err, frame_err, digit_count} !== 10'd0) begin
      $display("FAIL reset_outputs: got %b expected 0", {temperatura, lect, entry_err, frame_err, digit_count});
    end else pass_cnt++;
    rst_n = 1'b1;
    idle(20);
  endtask

  task automatic test_basic();
    clear_counts();
    send_byte(8'h16);
    @(negedge clk);
    total_cnt++;
    if (digit_count !== 2'd1) $display("FAIL basic_cnt1: got %0d expected 1", digit_count);
    else pass_cnt++;
    send_byte(8'h2E);
    @(negedge clk);
    total_cnt++;
    if (digit_count !== 2'd2) $display("FAIL basic_cnt2: got %0d expected 2", digit_count);
    else pass_cnt++;
    send_byte(8'h5A);
    @(negedge clk);
    total_cnt++;
    if (temperatura !== 5'd15) $display("FAIL basic_temp: got %0d expected 15", temperatura);
    else pass_cnt++;
    total_cnt++;
    if (lect_cnt !== 1) $display("FAIL basic_lect: got %0d expected 1", lect_cnt);
    else pass_cnt++;
    total_cnt++;
    if (digit_count !== 2'd0) $display("FAIL basic_cnt_clr: got %0d expected 0", digit_count);
    else pass_cnt++;
  endtask

  task automatic test_frame_err();
    clear_counts();
    send_byte(8'h1E);
    send_byte(8'h39, 1'b1);
    @(negedge clk);
    total_cnt++;
    if (ferr_cnt !== 1) $display("FAIL parity_ferr: got %0d expected 1", ferr_cnt);
    else pass_cnt++;
    send_byte(8'h5A);
    @(negedge clk);
    total_cnt++;
    if (temperatura !== 5'd2) $display("FAIL parity_temp: got %0d expected 2", temperatura);
    else pass_cnt++;
    total_cnt++;
    if (lect_cnt !== 1) $display("FAIL parity_lect: got %0d expected 1", lect_cnt);
    else pass_cnt++;
  endtask

  task automatic test_range();
    clear_counts();
    send_byte(8'h26); send_byte(8'h45); send_byte(8'h5A);
    @(negedge clk);
    total_cnt++;
    if (temperatura !== 5'd30) $display("FAIL range30_temp: got %0d expected 30", temperatura);
    else pass_cnt++;
    clear_counts();
    send_byte(8'h26); send_byte(8'h1E); send_byte(8'h5A);
    @(negedge clk);
    total_cnt++;
    if (eerr_cnt !== 1) $display("FAIL range32_eerr: got %0d expected 1", eerr_cnt);
    else pass_cnt++;
    total_cnt++;
    if (lect_cnt !== 0) $display("FAIL range32_lect: got %0d expected 0", lect_cnt);
    else pass_cnt++;
    total_cnt++;
    if (temperatura !== 5'd30) $display("FAIL range32_temp: got %0d expected 30", temperatura);
    else pass_cnt++;
    total_cnt++;
    if (digit_count !== 2'd0) $display("FAIL range32_cnt: got %0d expected 0", digit_count);
    else pass_cnt++;
  endtask

  task automatic test_release_backspace();
    clear_counts();
    send_byte(8'h16); send_byte(8'hF0); send_byte(8'h16); send_byte(8'h16);
    @(negedge clk);
    total_cnt++;
    if (digit_count !== 2'd2) $display("FAIL release_cnt: got %0d expected 2", digit_count);
    else pass_cnt++;
    send_byte(8'h66);
    @(negedge clk);
    total_cnt++;
    if (digit_count !== 2'd0) $display("FAIL bksp_cnt: got %0d expected 0", digit_count);
    else pass_cnt++;
    send_byte(8'h25); send_byte(8'hE0); send_byte(8'h5A);
    @(negedge clk);
    total_cnt++;
    if (temperatura !== 5'd4) $display("FAIL kp_enter_temp: got %0d expected 4", temperatura);
    else pass_cnt++;
    check("kp_enter_lect", lect_cnt, 1);
    check("kp_enter_eerr", eerr_cnt, 0);
  endtask

  task automatic test_overflow();
    clear_counts();
    send_byte(8'h16); send_byte(8'h16); send_byte(8'h16);
    @(negedge clk);
    check("ovf_eerr", eerr_cnt, 1);
    check("ovf_cnt", digit_count, 2);
    send_byte(8'h5A);
    @(negedge clk);
    check("ovf_temp", temperatura, 11);
    check("ovf_lect", lect_cnt, 1);
  endtask

  task automatic test_timeout_glitch();
    clear_counts();
    send_bits({1'b1, 1'b0, 8'h16, 1'b0}, 4);
    idle(TMO + 500);
    @(negedge clk);
    check("timeout_ferr", ferr_cnt, 1);
    clear_counts();
    @(posedge clk);
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    @(posedge clk);
    ps2_clk  = 1'b1;
    idle(HALF);
    ps2_data = 1'b1;
    send_byte(8'h1E); send_byte(8'h5A);
    @(negedge clk);
    check("glitch_temp", temperatura, 2);
    check("glitch_ferr", ferr_cnt, 0);
  endtask

  task automatic test_reset_mid();
    send_byte(8'h3E);
    send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 5);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_temp", temperatura, 0);
    check("midrst_cnt", digit_count, 0);
    check("midrst_pulses", {lect, entry_err, frame_err}, 0);
    idle(3);
    rst_n = 1'b1;
    idle(40);
    clear_counts();
    send_byte(8'h25); send_byte(8'h5A);
    @(negedge clk);
    check("midrst_after_temp", temperatura, 4);
    check("midrst_after_ferr", ferr_cnt, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_range();
    test_release_backspace();
    test_overflow();
    test_timeout_glitch();
    test_reset_mid();
    check("pulse_width", width_err, 0);
    check("temp_with_lect", temp_err, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
